// File: rtl/pattern_match_pkg.sv
// Shared FSM encodings and reset-default configuration for the pattern match controller.
package pattern_match_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] DEF_PATTERN = 8'b0011_0011;
  localparam int         DEF_LEN     = 6;
endpackage

// File: rtl/pattern_match_controller_window.sv
// Serial shift window with fill tracking and a length-masked pattern compare.
// The hit output looks at the window as it will be after the current bit is shifted in.
module pattern_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic               a,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  logic [MAX_LEN-1:0] win, win_next, mask;
  logic [LEN_W-1:0]   fill, fill_next;

  always_comb begin
    win_next  = (win << 1) | {{(MAX_LEN-1){1'b0}}, a};
    fill_next = (fill >= len) ? len : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len);
    hit = (len != '0) && (fill_next >= len) && ((win_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win  <= '0;
      fill <= '0;
    end else if (clear) begin
      win  <= '0;
      fill <= '0;
    end else if (shift) begin
      win  <= win_next;
      fill <= fill_next;
    end
  end
endmodule

// File: rtl/pattern_match_controller.sv
// Configure/run/report sequencer around a programmable serial pattern window.
// Counts overlapping matches; a run ends on target, timeout or abort.
module pattern_match_controller
  import pattern_match_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]     cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic [TO_W-1:0]              cfg_timeout,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         a,
  output logic                         detected,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [CNT_W-1:0]             match_count
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q, count_inc;
  logic [TO_W-1:0]    to_q, cyc, cyc_inc;
  logic               cfg_fire, new_err, go, hit, tgt_hit, to_hit;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  assign cfg_fire  = cfg_valid & cfg_ready;
  assign new_err   = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
  // A config offered alongside start is the one the run must use.
  assign go        = (state == IDLE) && start && !(cfg_fire ? new_err : cfg_err);

  assign count_inc = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  assign cyc_inc   = cyc + TO_W'(1);
  assign tgt_hit   = hit && (tgt_q != '0) && (count_inc == tgt_q);
  assign to_hit    = (to_q != '0) && (cyc_inc == to_q);

  pattern_window #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_window (
    .clk     (clk),
    .rst     (rst),
    .clear   (go),
    .shift   (busy),
    .a       (a),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= MAX_LEN'(DEF_PATTERN);
      len_q       <= LEN_W'(DEF_LEN);
      tgt_q       <= '0;
      to_q        <= '0;
      cfg_err     <= 1'b0;
      detected    <= 1'b0;
      timed_out   <= 1'b0;
      match_count <= '0;
      cyc         <= '0;
    end else begin
      detected <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            tgt_q   <= cfg_target;
            to_q    <= cfg_timeout;
            cfg_err <= new_err;
          end
          if (go) begin
            state       <= RUN;
            match_count <= '0;
            timed_out   <= 1'b0;
            cyc         <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cyc <= cyc_inc;
            if (hit) begin
              detected    <= 1'b1;
              match_count <= count_inc;
            end
            // Target beats timeout on the same edge.
            if (tgt_hit) begin
              state <= DONE;
            end else if (to_hit) begin
              state     <= DONE;
              timed_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_match_controller.sv
// Self-checking bench: directed scenarios plus randomized runs against a bit-history model.
module tb_pattern_match_controller;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;
  localparam int LEN_W   = 4;

  logic               clk = 0, rst = 1;
  logic               cfg_valid = 0, cfg_ready, cfg_err;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic [TO_W-1:0]    cfg_timeout = '0;
  logic               start = 0, abort = 0, a = 0;
  logic               detected, busy, done, timed_out;
  logic [CNT_W-1:0]   match_count;

  int checks = 0, failures = 0;

  // Reference: every bit received this run, oldest first.
  bit         hist[$];
  logic [7:0] m_pat = 8'b0011_0011;
  int         m_len = 6;

  pattern_match_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .cfg_err(cfg_err), .start(start), .abort(abort),
    .a(a), .detected(detected), .busy(busy), .done(done), .timed_out(timed_out),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Last m_len received bits, read oldest to newest, must spell pattern bits m_len-1 down to 0.
  function automatic bit model_hit();
    int n = hist.size();
    if (n < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++)
      if (hist[n - m_len + j] != m_pat[m_len - 1 - j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic feed(input bit b, output bit exp_det);
    a = b;
    hist.push_back(b);
    exp_det = model_hit();
    step();
    a = 0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input int tgt, input int to, input bit with_start);
    cfg_valid = 1; cfg_pattern = p; cfg_len = LEN_W'(l);
    cfg_target = CNT_W'(tgt); cfg_timeout = TO_W'(to); start = with_start;
    step();
    cfg_valid = 0; start = 0;
    if (l >= 1 && l <= MAX_LEN) begin m_pat = p; m_len = l; end
    if (with_start) hist.delete();
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
    hist.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++;
    if ({cfg_ready, cfg_err, detected, busy, done, timed_out, match_count} !== {1'b1, 5'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_outputs: got %b/%0d required 100000/0",
               {cfg_ready, cfg_err, detected, busy, done, timed_out}, match_count);
    end
    #2 rst = 0;
  endtask

  task automatic test_default_pattern();
    bit s[10] = '{1,1,0,0,1,1,0,0,1,1};
    bit e;
    do_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL default_busy_after_start: got %b required 1", busy); end
    for (int i = 0; i < 10; i++) begin
      feed(s[i], e);
      checks++;
      if (detected !== e || busy !== 1'b1) begin
        failures++;
        $display("FAIL default_bit%0d: detected/busy got %b%b required %b1", i + 1, detected, busy, e);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin failures++; $display("FAIL default_count: got %0d required 2", match_count); end
    abort = 1; step(); abort = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd2) begin
      failures++;
      $display("FAIL default_abort: busy/done/count got %b%b/%0d required 00/2", busy, done, match_count);
    end
  endtask

  task automatic test_target();
    bit s[6] = '{1,0,1,0,1,0};
    bit e;
    do_cfg(8'b1010, 4, 2, 0, 0);
    do_start();
    for (int i = 0; i < 6; i++) begin
      feed(s[i], e);
      checks++;
      if (detected !== e || done !== (i == 5) || busy !== (i != 5)) begin
        failures++;
        $display("FAIL target_bit%0d: det/done/busy got %b%b%b required %b%b%b",
                 i + 1, detected, done, busy, e, i == 5, i != 5);
      end
    end
    checks++;
    if (match_count !== 8'd2 || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL target_result: count/timed_out got %0d/%b required 2/0", match_count, timed_out);
    end
    step();
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || match_count !== 8'd2) begin
      failures++;
      $display("FAIL target_back_to_idle: done/ready/count got %b%b/%0d required 01/2", done, cfg_ready, match_count);
    end
  endtask

  task automatic test_timeout();
    bit e;
    do_cfg(8'b1010, 4, 1, 5, 0);
    do_start();
    for (int i = 1; i <= 5; i++) begin
      feed(1'b0, e);
      checks++;
      if (done !== (i == 5) || timed_out !== (i == 5) || detected !== 1'b0) begin
        failures++;
        $display("FAIL timeout_edge%0d: done/timed_out/det got %b%b%b required %b%b0",
                 i, done, timed_out, detected, i == 5, i == 5);
      end
    end
    checks++;
    if (match_count !== 8'd0) begin failures++; $display("FAIL timeout_count: got %0d required 0", match_count); end
    step();
  endtask

  task automatic test_cfg_err();
    do_cfg(8'b1, 0, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_len0: got %b required 1", cfg_err); end
    start = 1; step(); start = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cfg_err_start_ignored: busy got %b required 0", busy); end
    do_cfg(8'b1, 9, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_len9: got %b required 1", cfg_err); end
    do_cfg(8'b1010, 4, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_cleared: got %b required 0", cfg_err); end
    do_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL cfg_err_legal_run: busy got %b required 1", busy); end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_abort_priority();
    bit e;
    do_cfg(8'b1, 1, 0, 3, 0);
    do_start();
    feed(1'b0, e);
    feed(1'b1, e);
    checks++;
    if (detected !== 1'b1 || match_count !== 8'd1) begin
      failures++;
      $display("FAIL abort_first_match: det/count got %b/%0d required 1/1", detected, match_count);
    end
    a = 1; abort = 1; step(); abort = 0; a = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || detected !== 1'b0 || match_count !== 8'd1 || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_priority: busy/done/det/to/count got %b%b%b%b/%0d required 0000/1",
               busy, done, detected, timed_out, match_count);
    end
    step();
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_done: done/ready got %b%b required 01", done, cfg_ready);
    end
  endtask

  task automatic test_random();
    bit e, ended, exp_to;
    int tgt, to, cnt, cyc;
    for (int it = 0; it < 10; it++) begin
      tgt = $urandom_range(0, 3);
      to  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 30);
      do_cfg(8'($urandom), $urandom_range(1, 3), tgt, to, 1'($urandom_range(0, 1)));
      if (!busy) do_start();
      cnt = 0; cyc = 0; ended = 0; exp_to = 0;
      for (int k = 0; k < 60 && !ended; k++) begin
        feed(1'($urandom_range(0, 1)), e);
        cyc++;
        if (e && cnt < 255) cnt++;
        if (e && tgt != 0 && cnt == tgt) ended = 1;
        else if (to != 0 && cyc == to) begin ended = 1; exp_to = 1; end
        checks++;
        if (detected !== e || done !== ended || busy !== !ended || match_count !== CNT_W'(cnt)) begin
          failures++;
          $display("FAIL random_run%0d_bit%0d: det/done/busy/count got %b%b%b/%0d required %b%b%b/%0d",
                   it, k + 1, detected, done, busy, match_count, e, ended, !ended, cnt);
        end
      end
      if (ended) begin
        checks++;
        if (timed_out !== exp_to) begin
          failures++;
          $display("FAIL random_run%0d_timed_out: got %b required %b", it, timed_out, exp_to);
        end
        step();
      end else begin
        abort = 1; step(); abort = 0;
      end
    end
  endtask

  task automatic test_async_reset();
    bit s[6] = '{1,1,0,0,1,1};
    bit e;
    do_cfg(8'b1, 1, 0, 0, 0);
    do_start();
    feed(1'b1, e);
    #3 rst = 1;
    #1;
    checks++;
    if ({cfg_ready, cfg_err, detected, busy, done, timed_out, match_count} !== {1'b1, 5'b0, 8'd0}) begin
      failures++;
      $display("FAIL async_reset_outputs: got %b/%0d required 100000/0",
               {cfg_ready, cfg_err, detected, busy, done, timed_out}, match_count);
    end
    #10 rst = 0;
    m_pat = 8'b0011_0011; m_len = 6;
    do_start();
    for (int i = 0; i < 6; i++) begin
      feed(s[i], e);
      checks++;
      if (detected !== e) begin
        failures++;
        $display("FAIL post_reset_bit%0d: detected got %b required %b", i + 1, detected, e);
      end
    end
    checks++;
    if (match_count !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_count: count/busy got %0d/%b required 1/1", match_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_target();
    test_timeout();
    test_cfg_err();
    test_abort_priority();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pattern_match_controller.md
# pattern_match_controller

Sequences a programmable serial-pattern detector through configure, run and report phases. It accepts a pattern, pattern length, match target and timeout through a valid/ready config port, then runs on a `start` command. While running it counts overlapping occurrences of the pattern in the serial input `a`. It ends a run on target reached, timeout or abort, and reports through a `done` pulse and a held result. It sits between the serial stream and the test/control logic that previously hard-wired fixed-sequence detectors.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits.
- `CNT_W`, 8: width of match target and match counter.
- `TO_W`, 16: width of timeout, in cycles.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config accepted when `cfg_valid & cfg_ready`.
- `cfg_pattern` in MAX_LEN: pattern. Bit `cfg_len-1` is the first bit received.
- `cfg_len` in $clog2(MAX_LEN)+1: pattern length. Legal range is 1..MAX_LEN.
- `cfg_target` in CNT_W: number of matches that ends a run. 0 means unlimited.
- `cfg_timeout` in TO_W: maximum number of run cycles. 0 means no timeout.
- `cfg_err` out 1: latched config is illegal.
- `start` in 1: begin a run.
- `abort` in 1: terminate a run.
- `a` in 1: serial data.
- `detected` out 1: one-cycle pulse per match.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at end of run.
- `timed_out` out 1: last run ended by timeout.
- `match_count` out CNT_W: matches in the current or last run.

## Operation
- FSM states:
  - IDLE: `cfg_ready=1`. A handshake latches all config fields. `start` goes to RUN when `cfg_err=0`, otherwise `start` is ignored.
  - RUN: samples `a` every cycle. `start` and `cfg_valid` are ignored.
  - DONE: lasts one cycle. `done=1`. Always returns to IDLE.
- Reset config: pattern 6'b110011, len 6, target 0, timeout 0, `cfg_err=0`.
- `cfg_err` is set when the accepted `cfg_len` is 0 or greater than MAX_LEN, and cleared by the next legal config.
- On `start`:
  - clear `match_count`, `timed_out`, the shift window, the fill counter and the cycle counter;
  - enter RUN on the next edge.
- RUN, per edge:
  - shift `a` into the window, LSB = newest bit;
  - the fill counter saturates at `cfg_len`;
  - a match is when fill ≥ `cfg_len` and the low `cfg_len` window bits equal the low `cfg_len` pattern bits.
- Matches overlap. The window is not cleared after a match.
- On a match:
  - `match_count` increments, saturating at all-ones;
  - `detected` pulses.
- End conditions, evaluated on each RUN edge:
  - `abort` → IDLE immediately. No `done` pulse. `timed_out` is 0. `match_count` holds.
  - The match that makes `match_count == cfg_target` (target ≠ 0) → DONE with `timed_out=0`.
  - Otherwise, the cycle counter reaching `cfg_timeout` (timeout ≠ 0) → DONE with `timed_out=1`.
- Simultaneous events:
  - `start` and `cfg_valid` in the same IDLE cycle: the config is latched and the run uses the new config. `cfg_err` is evaluated on the new config.
  - Match and timeout on the same edge: the match is counted. If the target is reached, `timed_out=0`.
  - `abort` has priority over target and timeout.
- `abort` outside RUN has no effect.

## Timing
- Reset values of outputs:
  - `cfg_ready=1`; `cfg_err=0`; `detected=0`; `busy=0`; `done=0`; `timed_out=0`; `match_count=0`.
  - The FSM resets to IDLE.
- `start` sampled at edge N:
  - `busy=1` from N+1;
  - the first bit of `a` is sampled at edge N+1.
- A completing bit sampled at edge M gives:
  - `detected=1` and `match_count` updated during cycle M..M+1 (registered, Moore-style);
  - if that match reaches the target, state is DONE in the same cycle. `done` and `detected` coincide, and `busy=0`.
- Timeout: the cycle counter counts RUN edges. `done` is asserted in the cycle after the `cfg_timeout`-th RUN edge.
- Minimum run-to-run spacing: one IDLE cycle after DONE.
- `match_count` and `timed_out` hold from end of run until the next accepted `start`.

## Structure
- Package `pattern_match_pkg` holds:
  - the state enum `IDLE/RUN/DONE`;
  - the reset-default pattern and length constants.
- Sub-module `pattern_window`:
  - contains the shift register, fill counter and length-masked compare;
  - has a `clear` input;
  - outputs a combinational `hit`.
- The controller holds the FSM, config registers, counters and outputs.

## Test plan
- Reset defaults, then start, then stream 1,1,0,0,1,1,0,0,1,1 → `detected` after bits 6 and 10; `match_count`=2; `busy` stays high because target is 0.
- Config pattern 4'b1010, len 4, target 2; stream 1,0,1,0,1,0 → matches at bits 4 and 6; `done` with `detected` in the cycle after bit 6; `match_count`=2; `timed_out`=0.
- Config timeout 5, target 1; stream all zeros → `done` in the cycle after the 5th RUN edge; `timed_out`=1; `match_count`=0.
- Config len 0, then `start` → `cfg_err`=1 and `busy` stays 0. A legal config clears `cfg_err`, then `start` runs.
- `abort` mid-run after 1 match, with a match and timeout expiring on that same edge → IDLE with no `done`; `match_count`=1; `timed_out`=0.
- Assert `rst` mid-run → all outputs return to reset values immediately (asynchronous); the next run uses the default 110011 pattern.
